triangle_assembler: RTL and testbench
=====================================

TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 Parameter COUNT_W, default 16: width of the emitted-triangle counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 vtx_in  input  vertex_t  incoming vertex (celery_pkg type).
REQ-005 vtx_valid  input  1  vtx_in is valid.
REQ-006 vtx_ready  output  1  block accepts vtx_in this cycle.
REQ-007 prim_mode  input  1  0 = triangle list, 1 = triangle strip.
REQ-008 prim_restart  input  1  single-cycle pulse that starts a new primitive.
REQ-009 v0, v1, v2  output  vertex_t each  assembled triangle vertices, fed to the rasterizer vertex inputs.
REQ-010 tri_valid  output  1  v0/v1/v2 hold a complete triangle.
REQ-011 tri_ready  input  1  downstream accepts the triangle.
REQ-012 tri_count  output  COUNT_W  number of triangles handed off (tri_valid && tri_ready).
REQ-013 busy  output  1  partial primitive held or triangle pending.

Function
REQ-014 Vertex handshake: vertex accepted when vtx_valid && vtx_ready; vtx_ready = !tri_valid || tri_ready (combinational, no other dependency).
REQ-015 Triangle handshake: triangle consumed when tri_valid && tri_ready; v0/v1/v2 stable while tri_valid && !tri_ready.
REQ-016 Internal state: history slots s0, s1 (vertex_t); vcnt in {0,1,2}; parity bit; latched mode bit.
REQ-017 Mode latch: prim_mode sampled only on acceptance with vcnt==0; ignored at all other times.
REQ-018 List mode: accepts at vcnt 0 -> s0, vcnt 1 -> s1, vcnt 2 -> emit (v0=s0, v1=s1, v2=vtx_in), vcnt returns to 0.
REQ-019 Strip mode, vcnt 0/1: fill s0/s1 as in list mode; no emit.
REQ-020 Strip mode, vcnt 2, parity 0: emit (s0, s1, vtx_in).
REQ-021 Strip mode, vcnt 2, parity 1: emit (s1, s0, vtx_in), preserving winding.
REQ-022 Strip mode, vcnt 2, every emit: s0<=s1, s1<=vtx_in, parity toggles, vcnt stays 2.
REQ-023 Latency: accepting the completing vertex in cycle N sets tri_valid and loads v0/v1/v2 at edge N+1.
REQ-024 Throughput: back-to-back emit and consume in the same cycle is allowed; one triangle per cycle sustained in strip mode with tri_ready held high.
REQ-025 tri_valid clears on consumption unless a new triangle is loaded in the same cycle, in which case it stays 1.
REQ-026 Restart: prim_restart sets vcnt=0, parity=0; does not affect a pending tri_valid triangle.
REQ-027 Restart coinciding with vertex acceptance: restart applies first; that vertex becomes vcnt-0 vertex of the new primitive (mode re-latched).
REQ-028 tri_count increments by 1 per consumed triangle, wraps modulo 2^COUNT_W, no saturation.
REQ-029 busy = tri_valid || (vcnt != 0).
REQ-030 Degenerate or duplicate vertices are not filtered; the downstream setup unit rejects them.

Reset
REQ-031 On rst_n low, asynchronously: tri_valid=0, vcnt=0, parity=0, mode=0, tri_count=0, v0/v1/v2=0, s0/s1=0.
REQ-032 Reset mid-primitive or with a pending triangle discards it; no triangle is emitted after release until 3 fresh vertices arrive.
REQ-033 vtx_ready is 1 during and immediately after reset.

Verification
REQ-034 List mode: feed A,B,C,D,E,F with tri_ready=1 -> triangles (A,B,C), (D,E,F); tri_count=2; busy=0 after.
REQ-035 Strip mode: feed A,B,C,D,E with tri_ready=1 -> (A,B,C), (C,B,D), (C,D,E) on consecutive cycles; tri_count=3.
REQ-036 Backpressure: strip mode, tri_ready=0 for 5 cycles after first emit -> vtx_ready=0, v0..v2 hold (A,B,C); release -> no loss or duplication.
REQ-037 Restart: strip A,B,C, then restart coinciding with D, then E,F -> (A,B,C), (D,E,F); parity reset, no (B,C,D) emitted.
REQ-038 Mode latch: list mode, prim_mode toggled to 1 after A -> A,B,C,D,E,F still yield list triangles only.
REQ-039 Reset mid-strip with tri_valid=1 -> tri_valid=0, tri_count=0 immediately; next 2 vertices produce no triangle.

Source files
------------

// File: rtl/triangle_assembler.sv
// Triangle assembler: collects vertices into list or strip triangles and
// hands them to the rasterizer over a valid/ready interface. The celery_pkg
// package that defines the vertex type sits at the top of this file.

package celery_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;
endpackage

module triangle_assembler
  import celery_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  vertex_t            vtx_in,
  input  logic               vtx_valid,
  output logic               vtx_ready,
  input  logic               prim_mode,
  input  logic               prim_restart,
  output vertex_t            v0,
  output vertex_t            v1,
  output vertex_t            v2,
  output logic               tri_valid,
  input  logic               tri_ready,
  output logic [COUNT_W-1:0] tri_count,
  output logic               busy
);

  localparam logic [1:0] VCNT_0 = 2'd0;
  localparam logic [1:0] VCNT_1 = 2'd1;
  localparam logic [1:0] VCNT_2 = 2'd2;

  localparam logic MODE_LIST  = 1'b0;
  localparam logic MODE_STRIP = 1'b1;

  // History and primitive state
  vertex_t    s0, s1;
  logic [1:0] vcnt;
  logic       parity;
  logic       mode;

  // Next-state values
  vertex_t    s0_n, s1_n;
  logic [1:0] vcnt_n;
  logic       parity_n;
  logic       mode_n;
  logic       emit;
  vertex_t    e0, e1;

  // Restart takes effect before the vertex in the same cycle is placed.
  logic [1:0] vcnt_eff;
  logic       parity_eff;
  logic       accept;
  logic       consume;

  // A new vertex may enter whenever the output slot is empty or draining.
  assign vtx_ready  = !tri_valid || tri_ready;
  assign accept     = vtx_valid && vtx_ready;
  assign consume    = tri_valid && tri_ready;
  assign vcnt_eff   = prim_restart ? VCNT_0 : vcnt;
  assign parity_eff = prim_restart ? 1'b0 : parity;
  assign busy       = tri_valid || (vcnt != VCNT_0);

  // Slot filling, emit decision and strip window shift
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    s0_n     = s0;
    s1_n     = s1;
    vcnt_n   = vcnt_eff;
    parity_n = parity_eff;
    mode_n   = mode;
    emit     = 1'b0;
    e0       = s0;
    e1       = s1;
    if (accept) begin
      case (vcnt_eff)
        VCNT_0: begin
          s0_n   = vtx_in;
          vcnt_n = VCNT_1;
          mode_n = prim_mode;
        end
        VCNT_1: begin
          s1_n   = vtx_in;
          vcnt_n = VCNT_2;
        end
        default: begin
          emit = 1'b1;
          if (mode == MODE_STRIP) begin
            // Odd strip triangles swap the first two vertices to keep winding.
            if (parity_eff) begin
              e0 = s1;
              e1 = s0;
            end
            s0_n     = s1;
            s1_n     = vtx_in;
            parity_n = !parity_eff;
          end else begin
            vcnt_n = VCNT_0;
          end
        end
      endcase
    end
  end

  // Primitive state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0     <= '0;
      s1     <= '0;
      vcnt   <= VCNT_0;
      parity <= 1'b0;
      mode   <= MODE_LIST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      s0     <= s0_n;
      s1     <= s1_n;
      vcnt   <= vcnt_n;
      parity <= parity_n;
      mode   <= mode_n;
    end
  end

  // Output triangle slot: load on emit, hold under backpressure, clear on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_valid <= 1'b0;
      v0        <= '0;
      v1        <= '0;
      v2        <= '0;
    end else begin
      if (emit) begin
        tri_valid <= 1'b1;
        v0        <= e0;
        v1        <= e1;
        v2        <= vtx_in;
      end else if (consume) begin
        tri_valid <= 1'b0;
      end
    end
  end

  // Handed-off triangle counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_count <= '0;
    end else if (consume) begin
      tri_count <= tri_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: list, strip, backpressure, restart,
// mode latch and mid-primitive reset.

module tb_triangle_assembler;
  import celery_pkg::*;

  localparam int COUNT_W = 16;

  logic               clk;
  logic               rst_n;
  vertex_t            vtx_in;
  logic               vtx_valid;
  logic               vtx_ready;
  logic               prim_mode;
  logic               prim_restart;
  vertex_t            v0, v1, v2;
  logic               tri_valid;
  logic               tri_ready;
  logic [COUNT_W-1:0] tri_count;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  triangle_assembler #(.COUNT_W(COUNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vtx_in       (vtx_in),
    .vtx_valid    (vtx_valid),
    .vtx_ready    (vtx_ready),
    .prim_mode    (prim_mode),
    .prim_restart (prim_restart),
    .v0           (v0),
    .v1           (v1),
    .v2           (v2),
    .tri_valid    (tri_valid),
    .tri_ready    (tri_ready),
    .tri_count    (tri_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vertex_t mk(input int n);
    vertex_t v;
    v.x = 16'(n);
    v.y = 16'(n * 7 + 3);
    v.z = 16'(16'hA000 + n);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tri(input string tag, input vertex_t a, input vertex_t b, input vertex_t c);
    chk({tag, ".valid"}, 64'(tri_valid), 64'(1'b1));
    chk({tag, ".v0"}, 64'(v0), 64'(a));
    chk({tag, ".v1"}, 64'(v1), 64'(b));
    chk({tag, ".v2"}, 64'(v2), 64'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vertex_t v);
    vtx_valid = 1'b1;
    vtx_in    = v;
    tick();
  endtask

  task automatic idle();
    vtx_valid = 1'b0;
    tick();
  endtask

  task automatic restart();
    vtx_valid    = 1'b0;
    prim_restart = 1'b1;
    tick();
    prim_restart = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    vtx_in       = '0;
    vtx_valid    = 1'b0;
    prim_mode    = 1'b0;
    prim_restart = 1'b0;
    tri_ready    = 1'b1;

    // Reset state
    #12;
    chk("rst.vtx_ready", 64'(vtx_ready), 64'(1'b1));
    chk("rst.tri_valid", 64'(tri_valid), 64'(1'b0));
    chk("rst.tri_count", 64'(tri_count), 64'(0));
    chk("rst.busy", 64'(busy), 64'(1'b0));
    chk("rst.v0", 64'(v0), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst.vtx_ready", 64'(vtx_ready), 64'(1'b1));

    // List mode: A..F -> (A,B,C), (D,E,F)
    prim_mode = 1'b0;
    send(mk(1));
    send(mk(2));
    chk("list.no_tri_b", 64'(tri_valid), 64'(1'b0));
    send(mk(3));
    chk_tri("list.t0", mk(1), mk(2), mk(3));
    chk("list.busy_t0", 64'(busy), 64'(1'b1));
    send(mk(4));
    chk("list.no_tri_d", 64'(tri_valid), 64'(1'b0));
    chk("list.count1", 64'(tri_count), 64'(1));
    send(mk(5));
    chk("list.no_tri_e", 64'(tri_valid), 64'(1'b0));
    send(mk(6));
    chk_tri("list.t1", mk(4), mk(5), mk(6));
    idle();
    chk("list.count2", 64'(tri_count), 64'(2));
    chk("list.busy_end", 64'(busy), 64'(1'b0));

    // Strip mode: A..E -> (A,B,C), (C,B,D), (C,D,E) back to back
    prim_mode = 1'b1;
    send(mk(11));
    send(mk(12));
    send(mk(13));
    chk_tri("strip.t0", mk(11), mk(12), mk(13));
    send(mk(14));
    chk_tri("strip.t1", mk(13), mk(12), mk(14));
    chk("strip.count3", 64'(tri_count), 64'(3));
    send(mk(15));
    chk_tri("strip.t2", mk(13), mk(14), mk(15));
    idle();
    chk("strip.count5", 64'(tri_count), 64'(5));
    chk("strip.tri_drained", 64'(tri_valid), 64'(1'b0));
    chk("strip.busy_held", 64'(busy), 64'(1'b1));
    restart();
    chk("strip.busy_restart", 64'(busy), 64'(1'b0));

    // Backpressure: hold (A,B,C) for 5 cycles with D waiting
    send(mk(21));
    send(mk(22));
    send(mk(23));
    chk_tri("bp.t0", mk(21), mk(22), mk(23));
    tri_ready = 1'b0;
    vtx_in    = mk(24);
    #1;
    chk("bp.vtx_ready_low", 64'(vtx_ready), 64'(1'b0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_tri($sformatf("bp.hold%0d", i), mk(21), mk(22), mk(23));
      chk($sformatf("bp.stall_rdy%0d", i), 64'(vtx_ready), 64'(1'b0));
    end
    chk("bp.count_hold", 64'(tri_count), 64'(5));
    tri_ready = 1'b1;
    #1;
    chk("bp.vtx_ready_high", 64'(vtx_ready), 64'(1'b1));
    tick();
    chk_tri("bp.t1", mk(23), mk(22), mk(24));
    chk("bp.count6", 64'(tri_count), 64'(6));
    send(mk(25));
    chk_tri("bp.t2", mk(23), mk(24), mk(25));
    idle();
    chk("bp.count8", 64'(tri_count), 64'(8));
    restart();

    // Restart coinciding with D: (A,B,C), then (D,E,F), never (B,C,D)
    send(mk(31));
    send(mk(32));
    send(mk(33));
    chk_tri("rs.t0", mk(31), mk(32), mk(33));
    prim_restart = 1'b1;
    send(mk(34));
    prim_restart = 1'b0;
    chk("rs.no_tri_d", 64'(tri_valid), 64'(1'b0));
    chk("rs.count9", 64'(tri_count), 64'(9));
    send(mk(35));
    chk("rs.no_tri_e", 64'(tri_valid), 64'(1'b0));
    send(mk(36));
    chk_tri("rs.t1", mk(34), mk(35), mk(36));
    idle();
    chk("rs.count10", 64'(tri_count), 64'(10));
    restart();

    // Mode latch: list primitive, prim_mode raised after A is ignored
    prim_mode = 1'b0;
    send(mk(41));
    prim_mode = 1'b1;
    send(mk(42));
    send(mk(43));
    chk_tri("ml.t0", mk(41), mk(42), mk(43));
    prim_mode = 1'b0;
    send(mk(44));
    chk("ml.no_tri_d", 64'(tri_valid), 64'(1'b0));
    send(mk(45));
    chk("ml.no_tri_e", 64'(tri_valid), 64'(1'b0));
    send(mk(46));
    chk_tri("ml.t1", mk(44), mk(45), mk(46));
    idle();
    chk("ml.count12", 64'(tri_count), 64'(12));
    chk("ml.busy_end", 64'(busy), 64'(1'b0));

    // Reset mid-strip with a pending triangle
    prim_mode = 1'b1;
    send(mk(51));
    send(mk(52));
    tri_ready = 1'b0;
    send(mk(53));
    chk_tri("mr.t0", mk(51), mk(52), mk(53));
    vtx_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("mr.tri_valid", 64'(tri_valid), 64'(1'b0));
    chk("mr.tri_count", 64'(tri_count), 64'(0));
    chk("mr.busy", 64'(busy), 64'(1'b0));
    chk("mr.vtx_ready", 64'(vtx_ready), 64'(1'b1));
    #1;
    rst_n     = 1'b1;
    tri_ready = 1'b1;
    send(mk(54));
    chk("mr.no_tri_1", 64'(tri_valid), 64'(1'b0));
    send(mk(55));
    chk("mr.no_tri_2", 64'(tri_valid), 64'(1'b0));
    chk("mr.busy_partial", 64'(busy), 64'(1'b1));
    send(mk(56));
    chk_tri("mr.t1", mk(54), mk(55), mk(56));
    idle();
    chk("mr.count1", 64'(tri_count), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
